// File: rtl/monitor_packetizer_if.sv
// Word handshake between a monitor-word producer and monitor_packetizer.
// master drives the word and valid; slave returns ready.
interface monitor_packetizer_if #(
  parameter int unsigned WORD_BYTES = 4
);
  logic [8*WORD_BYTES-1:0] word_data;
  logic                    word_valid;
  logic                    word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/monitor_packetizer.sv
// Buffers monitor words and frames each as HEADER, data bytes MSB-first, checksum,
// strobing the RS-232C transmitter with a fixed cycle spacing per byte.
module monitor_packetizer #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned START_HOLD = 4,
  parameter int unsigned BYTE_GAP   = 400
) (
  input  logic                 clk,
  input  logic                 rst_n,
  monitor_packetizer_if.slave  word_if,
  output logic [7:0]           send_monitor_value,
  output logic                 send_monitor_start,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned WORD_W  = 8 * WORD_BYTES;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(WORD_BYTES + 2);
  localparam int unsigned CNT_W   = $clog2(BYTE_GAP + 1);
  localparam int unsigned GAP_LEN = BYTE_GAP - START_HOLD;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_BYTES + 1);
  localparam logic [IDX_W-1:0]  IDX_CSUM1 = IDX_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_LEN - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    GAP   = 2'd2
  } state_t;

  // ---------------- word FIFO ----------------
  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic              push, pop;
  logic [WORD_W-1:0] head_word;

  // ---------------- framer ----------------
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        value_q, value_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  assign word_if.word_ready = (fifo_cnt_q != FIFO_FULL);
  assign push      = word_if.word_valid && (fifo_cnt_q != FIFO_FULL);
  assign pop       = (state_q == IDLE) && (fifo_cnt_q != '0);
  assign head_word = fifo_mem[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= word_if.word_data;
    end
  end

  // One down-counter times both the strobe hold and the inter-byte gap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    csum_d  = csum_q;
    value_d = value_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_cnt_q != '0) begin
          shift_d = head_word;
          csum_d  = 8'h00;
          idx_d   = '0;
          value_d = HEADER;
          cnt_d   = HOLD_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = HOLD_LOAD;
            state_d = START;
            if (idx_q == IDX_CSUM1) begin
              value_d = csum_q;
            end else begin
              value_d = shift_q[WORD_W-1 -: 8];
              csum_d  = csum_q + shift_q[WORD_W-1 -: 8];
              shift_d = shift_q << 8;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          // Registered pulse must land on the final gap cycle.
          if ((cnt_q == CNT_W'(1)) && (idx_q == IDX_LAST)) begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      csum_q     <= 8'h00;
      value_q    <= 8'h00;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      value_q    <= value_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign send_monitor_value = value_q;
  assign send_monitor_start = start_q;
  assign busy               = busy_q;
  assign frame_done         = done_q;

endmodule

// File: tb/tb_monitor_packetizer.sv
// Directed bench for monitor_packetizer: frame bytes, strobe timing, checksum wrap,
// backpressure ordering and mid-frame reset abort.
module tb_monitor_packetizer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value;
  logic       start;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  monitor_packetizer_if #(.WORD_BYTES(4)) wif ();

  monitor_packetizer #(
    .WORD_BYTES(4),
    .FIFO_DEPTH(4),
    .HEADER    (8'hA5),
    .START_HOLD(4),
    .BYTE_GAP  (400)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .word_if           (wif),
    .send_monitor_value(value),
    .send_monitor_start(start),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle n is the interval following edge n of the current test.
  int         edge_cnt = 0;
  int         base = 0;
  int         rise_cyc[$];
  logic [7:0] rise_val[$];
  int         hold_len[$];
  int         done_cyc[$];
  int         bad_val = 0;
  int         hold_cnt = 0;
  logic       prev_start = 1'b0;
  logic [7:0] prev_value = 8'h00;
  int         first_block = -1;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start <= 1'b0;
      prev_value <= 8'h00;
      hold_cnt   <= 0;
    end else begin
      if (start && !prev_start) begin
        rise_cyc.push_back(edge_cnt - base + 1);
        rise_val.push_back(value);
      end else if (value !== prev_value) begin
        bad_val <= bad_val + 1;
      end
      if (start) begin
        hold_cnt <= prev_start ? hold_cnt + 1 : 1;
      end else if (prev_start) begin
        hold_len.push_back(hold_cnt);
      end
      if (frame_done) begin
        done_cyc.push_back(edge_cnt - base + 1);
      end
      prev_start <= start;
      prev_value <= value;
    end
  end

  // Called at a negedge; leaves word_valid high so words can be streamed back to back.
  task automatic push_word(input logic [31:0] w, output int acc);
    logic r;
    bit   ok;
    ok  = 1'b0;
    acc = -1;
    wif.word_data  = w;
    wif.word_valid = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      r = wif.word_ready;
      if (!r && first_block < 0) first_block = edge_cnt - base + 1;
      if (r) acc = edge_cnt - base + 1;
      @(posedge clk);
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accepted", 32'(ok), 32'd1);
    $display("push word %08h accepted at cycle %0d", w, acc);
  endtask

  task automatic wait_frames(input int n_total, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() >= n_total) break;
      @(negedge clk);
    end
    check("frames_seen", 32'(done_cyc.size()), 32'(n_total));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_value"}, 32'(value), 32'h00);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_ready"}, 32'(wif.word_ready), 32'd1);
  endtask

  logic [7:0]  exp_single [6] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
  logic [7:0]  exp_abort  [6] = '{8'hA5, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hC5};
  logic [31:0] bp_words   [6] = '{32'h11223344, 32'h55667788, 32'h99AABBCC,
                                  32'hDDEEFF00, 32'h01020304, 32'hA0B0C0D0};
  logic [7:0]  bp_csum    [6] = '{8'hAA, 8'hBA, 8'hCA, 8'hCA, 8'h0A, 8'hE0};

  initial begin
    int          acc;
    int          n0, d0, h0, n1, d1;
    logic [31:0] w;
    wif.word_valid = 1'b0;
    wif.word_data  = '0;

    // Reset state
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single word framing and timing
    n0 = rise_cyc.size(); d0 = done_cyc.size(); h0 = hold_len.size();
    base = edge_cnt + 1;
    push_word(32'h12345678, acc);
    wif.word_valid = 1'b0;
    check("single_accept_cycle", 32'(acc), 32'd0);
    wait_frames(d0 + 1, 3000);
    @(negedge clk);
    check("single_rises", 32'(rise_cyc.size() - n0), 32'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("single_rise%0d_cycle", k), 32'(rise_cyc[n0 + k]), 32'(2 + 400 * k));
      check($sformatf("single_rise%0d_value", k), 32'(rise_val[n0 + k]), 32'(exp_single[k]));
      check($sformatf("single_hold%0d", k), 32'(hold_len[h0 + k]), 32'd4);
    end
    check("single_done_cycle", 32'(done_cyc[d0]), 32'd2401);
    check("value_stable", 32'(bad_val), 32'd0);

    // Checksum wrap
    n0 = rise_cyc.size(); d0 = done_cyc.size();
    base = edge_cnt + 1;
    push_word(32'hFFFFFFFF, acc);
    wif.word_valid = 1'b0;
    wait_frames(d0 + 1, 3000);
    check("wrap_ff_data", 32'(rise_val[n0 + 1]), 32'hFF);
    check("wrap_ff_csum", 32'(rise_val[n0 + 5]), 32'hFC);
    n0 = rise_cyc.size(); d0 = done_cyc.size();
    base = edge_cnt + 1;
    push_word(32'h00000000, acc);
    wif.word_valid = 1'b0;
    wait_frames(d0 + 1, 3000);
    check("wrap_00_csum", 32'(rise_val[n0 + 5]), 32'h00);

    // Backpressure with valid held high
    n0 = rise_cyc.size(); d0 = done_cyc.size();
    first_block = -1;
    base = edge_cnt + 1;
    for (int i = 0; i < 6; i++) begin
      push_word(bp_words[i], acc);
      if (i == 4) check("bp_word4_accept", 32'(acc), 32'd4);
      if (i == 5) check("bp_word5_accept", 32'(acc), 32'd2403);
    end
    wif.word_valid = 1'b0;
    check("bp_ready_low_cycle", 32'(first_block), 32'd5);
    wait_frames(d0 + 6, 6 * 2401 + 3000);
    @(negedge clk);
    check("bp_rises", 32'(rise_cyc.size() - n0), 32'd36);
    for (int f = 0; f < 6; f++) begin
      w = bp_words[f];
      check($sformatf("bp_f%0d_hdr_cycle", f), 32'(rise_cyc[n0 + 6 * f]), 32'(2 + 2401 * f));
      check($sformatf("bp_f%0d_hdr", f), 32'(rise_val[n0 + 6 * f]), 32'hA5);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("bp_f%0d_b%0d", f, k), 32'(rise_val[n0 + 6 * f + 1 + k]),
              32'(w[31 - 8 * k -: 8]));
      end
      check($sformatf("bp_f%0d_csum", f), 32'(rise_val[n0 + 6 * f + 5]), 32'(bp_csum[f]));
      check($sformatf("bp_f%0d_done", f), 32'(done_cyc[d0 + f]), 32'(2401 * (f + 1)));
    end

    // Reset mid-frame, with a second word still queued
    n0 = rise_cyc.size();
    base = edge_cnt + 1;
    push_word(32'hDEADBEEF, acc);
    push_word(32'h0BADF00D, acc);
    wif.word_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rise_cyc.size() >= n0 + 3) break;
      @(negedge clk);
    end
    check("abort_reached_idx2", 32'(rise_cyc.size() - n0), 32'd3);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n1 = rise_cyc.size(); d1 = done_cyc.size();
    base = edge_cnt + 1;
    push_word(32'hCAFEF00D, acc);
    wif.word_valid = 1'b0;
    wait_frames(d1 + 1, 3000);
    repeat (600) @(negedge clk);
    check("abort_rises", 32'(rise_cyc.size() - n1), 32'd6);
    check("abort_hdr_cycle", 32'(rise_cyc[n1]), 32'd2);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort_byte%0d", k), 32'(rise_val[n1 + k]), 32'(exp_abort[k]));
    end
    check("abort_busy_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
